bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 53 +++++
 rtl/bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Shared-memory arbiter bundle: IFU and LSU request/response channels plus the memory port.
// Latency: none, signal grouping only.
// Backpressure: req held until gnt on the master side; mem_ready throttles the memory side.
interface bus_arbiter_if;
   // Instruction-fetch channel (read only)
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_gnt;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        ifu_err;

   // Load/store channel
   logic        lsu_req;
   logic        lsu_wen;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_gnt;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        lsu_err;

   // Shared memory port
   logic        mem_req;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   // Arbiter view
   modport slave (
      input  ifu_req, ifu_addr,
      output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
      input  lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
      output lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
      output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   // Environment view: requesters and memory
   modport master (
      output ifu_req, ifu_addr,
      input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
      output lsu_req, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
      input  lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
      input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Latency: gnt combinational in IDLE, mem_req next cycle, response earliest two cycles after gnt.
// Backpressure: losing/late requester holds req until gnt; mem_ready stalls REQ; TIMEOUT ends stuck accesses.
module bus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic          clock,
   input  logic          reset,
   bus_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;

   // Owner and last-granted: 1 = LSU, 0 = IFU
   logic        owner_lsu;
   logic        last_lsu;
   logic [31:0] tmo_cnt;

   // Latched payload of the current owner
   logic        pay_wen;
   logic [31:0] pay_addr;
   logic [31:0] pay_wdata;
   logic [3:0]  pay_wmask;

   logic        pick_lsu;
   logic        timed_out;
   logic        load;
   logic        grant_ifu;
   logic        grant_lsu;
   logic        issue;
   logic        done;
   logic        done_err;
   logic        done_ok;

   // Tie-break: a lone requester wins, on a tie the master not granted last wins
   always_comb begin
      pick_lsu  = bus.lsu_req && (!bus.ifu_req || !last_lsu);
      timed_out = (tmo_cnt >= TMO_LIMIT);
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle control; reset masks every pulse so nothing leaks out mid-reset
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;
      issue     = 1'b0;
      done      = 1'b0;
      done_err  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ifu_req || bus.lsu_req) begin
               load      = 1'b1;
               grant_lsu = pick_lsu;
               grant_ifu = !pick_lsu;
               state_nxt = REQ;
            end
         end
         REQ: begin
            // A response arriving together with ready is not taken here; it is expected in WAIT
            issue = 1'b1;
            if (timed_out) begin
               done      = 1'b1;
               done_err  = 1'b1;
               state_nxt = IDLE;
            end else if (bus.mem_ready) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            // A real response beats a timeout landing in the same cycle
            if (bus.mem_rvalid) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (timed_out) begin
               done      = 1'b1;
               done_err  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (reset) begin
         state_nxt = IDLE;
         load      = 1'b0;
         grant_ifu = 1'b0;
         grant_lsu = 1'b0;
         issue     = 1'b0;
         done      = 1'b0;
         done_err  = 1'b0;
      end
   end

   // Owner, round-robin history, payload capture and timeout counter
   always_ff @(posedge clock) begin
      if (reset) begin
         owner_lsu <= 1'b0;
         last_lsu  <= 1'b0;
         tmo_cnt   <= '0;
         pay_wen   <= 1'b0;
         pay_addr  <= '0;
         pay_wdata <= '0;
         pay_wmask <= '0;
      end else if (load) begin
         owner_lsu <= pick_lsu;
         last_lsu  <= pick_lsu;
         tmo_cnt   <= '0;
         if (pick_lsu) begin
            pay_wen   <= bus.lsu_wen;
            pay_addr  <= bus.lsu_addr;
            pay_wdata <= bus.lsu_wdata;
            pay_wmask <= bus.lsu_wmask;
         end else begin
            // Fetches are always plain reads
            pay_wen   <= 1'b0;
            pay_addr  <= bus.ifu_addr;
            pay_wdata <= '0;
            pay_wmask <= '0;
         end
      end else if (state != IDLE && tmo_cnt != '1) begin
         // Saturate so a huge TIMEOUT never wraps back to zero
         tmo_cnt <= tmo_cnt + 32'd1;
      end
   end

   // Completed access with valid data (timeouts return zero data)
   assign done_ok = done && !done_err;

   assign bus.ifu_gnt    = grant_ifu;
   assign bus.lsu_gnt    = grant_lsu;

   assign bus.ifu_rvalid = done && !owner_lsu;
   assign bus.ifu_err    = done_err && !owner_lsu;
   assign bus.ifu_rdata  = (done_ok && !owner_lsu) ? bus.mem_rdata : 32'h0;

   assign bus.lsu_rvalid = done && owner_lsu;
   assign bus.lsu_err    = done_err && owner_lsu;
   assign bus.lsu_rdata  = (done_ok && owner_lsu) ? bus.mem_rdata : 32'h0;

   assign bus.mem_req    = issue;
   assign bus.mem_wen    = reset ? 1'b0  : pay_wen;
   assign bus.mem_addr   = reset ? 32'h0 : pay_addr;
   assign bus.mem_wdata  = reset ? 32'h0 : pay_wdata;
   assign bus.mem_wmask  = reset ? 4'h0  : pay_wmask;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized back-to-back traffic.
// Inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// A second instance with TIMEOUT=4 exercises the forced termination path.
module tb_bus_arbiter;

   logic clock = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   bit   last_lsu_m;   // model: which master was granted last

   // Control vector layout: {ifu_gnt, lsu_gnt, mem_req, ifu_rvalid, ifu_err, lsu_rvalid, lsu_err}
   localparam logic [6:0] G_IFU = 7'b1000000;
   localparam logic [6:0] G_LSU = 7'b0100000;
   localparam logic [6:0] MREQ  = 7'b0010000;
   localparam logic [6:0] R_IFU = 7'b0001000;
   localparam logic [6:0] E_IFU = 7'b0000100;
   localparam logic [6:0] R_LSU = 7'b0000010;
   localparam logic [6:0] E_LSU = 7'b0000001;
   localparam logic [6:0] NONE  = 7'b0000000;

   always #5 clock = ~clock;

   bus_arbiter_if bi ();
   bus_arbiter_if bt ();

   bus_arbiter #(.TIMEOUT(255)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bi)
   );

   bus_arbiter #(.TIMEOUT(4)) dut_tmo (
      .clock (clock),
      .reset (reset),
      .bus   (bt)
   );

   function automatic logic [6:0] ctl_a();
      return {bi.ifu_gnt, bi.lsu_gnt, bi.mem_req, bi.ifu_rvalid, bi.ifu_err, bi.lsu_rvalid, bi.lsu_err};
   endfunction

   function automatic logic [6:0] ctl_t();
      return {bt.ifu_gnt, bt.lsu_gnt, bt.mem_req, bt.ifu_rvalid, bt.ifu_err, bt.lsu_rvalid, bt.lsu_err};
   endfunction

   function automatic logic [68:0] pay_a();
      return {bi.mem_wen, bi.mem_addr, bi.mem_wdata, bi.mem_wmask};
   endfunction

   task automatic clear_inputs();
      bi.ifu_req = 0; bi.ifu_addr = 0;
      bi.lsu_req = 0; bi.lsu_wen = 0; bi.lsu_addr = 0; bi.lsu_wdata = 0; bi.lsu_wmask = 0;
      bi.mem_ready = 0; bi.mem_rvalid = 0; bi.mem_rdata = 0;
      bt.ifu_req = 0; bt.ifu_addr = 0;
      bt.lsu_req = 0; bt.lsu_wen = 0; bt.lsu_addr = 0; bt.lsu_wdata = 0; bt.lsu_wmask = 0;
      bt.mem_ready = 0; bt.mem_rvalid = 0; bt.mem_rdata = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1;
      bi.ifu_req = 1; bi.lsu_req = 1; bi.ifu_addr = $urandom; bi.lsu_addr = $urandom;
      bi.mem_ready = 1; bi.mem_rvalid = 1; bi.mem_rdata = $urandom;
      bt.ifu_req = 1; bt.mem_rvalid = 1;
      tick();
      tick();
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl_a(), NONE); end
      total++; if (pay_a() !== 69'h0) begin bad++; $display("FAIL reset_payload: got %h want 0", pay_a()); end
      total++; if ({bi.ifu_rdata, bi.lsu_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", {bi.ifu_rdata, bi.lsu_rdata}); end
      total++; if (ctl_t() !== NONE) begin bad++; $display("FAIL reset_ctl_tmo: got %b want %b", ctl_t(), NONE); end
      tick();
      reset = 0;
      clear_inputs();
      last_lsu_m = 0;
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL post_reset_ctl: got %b want %b", ctl_a(), NONE); end
      total++; if (pay_a() !== 69'h0) begin bad++; $display("FAIL post_reset_payload: got %h want 0", pay_a()); end
      tick();
   endtask

   task automatic test_basic_fetch();
      logic [68:0] exp_pay;
      exp_pay = {1'b0, 32'h80000000, 32'h0, 4'h0};
      bi.ifu_req = 1; bi.ifu_addr = 32'h80000000;
      @(negedge clock);
      total++; if (ctl_a() !== G_IFU) begin bad++; $display("FAIL basic_gnt: got %b want %b", ctl_a(), G_IFU); end
      tick();
      // address may change after the grant; the latched copy must not
      bi.ifu_req = 0; bi.ifu_addr = $urandom; bi.mem_ready = 1;
      @(negedge clock);
      total++; if (ctl_a() !== MREQ) begin bad++; $display("FAIL basic_memreq: got %b want %b", ctl_a(), MREQ); end
      total++; if (pay_a() !== exp_pay) begin bad++; $display("FAIL basic_payload: got %h want %h", pay_a(), exp_pay); end
      tick();
      bi.mem_ready = 0; bi.mem_rvalid = 1; bi.mem_rdata = 32'h00000413;
      @(negedge clock);
      total++; if (ctl_a() !== R_IFU) begin bad++; $display("FAIL basic_rvalid: got %b want %b", ctl_a(), R_IFU); end
      total++; if (bi.ifu_rdata !== 32'h00000413) begin bad++; $display("FAIL basic_rdata: got %h want %h", bi.ifu_rdata, 32'h00000413); end
      tick();
      bi.mem_rvalid = 0;
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL basic_idle: got %b want %b", ctl_a(), NONE); end
      last_lsu_m = 0;
      tick();
   endtask

   task automatic test_arbitration();
      bit          win;
      logic [31:0] rd;
      logic [68:0] exp_pay;
      reset = 1;
      tick();
      reset = 0;
      last_lsu_m = 0;
      bi.ifu_req = 1; bi.ifu_addr = $urandom;
      bi.lsu_req = 1; bi.lsu_wen = 1'($urandom); bi.lsu_addr = $urandom; bi.lsu_wdata = $urandom; bi.lsu_wmask = 4'($urandom);
      for (int k = 0; k < 3; k++) begin
         win = !last_lsu_m;
         exp_pay = win ? {bi.lsu_wen, bi.lsu_addr, bi.lsu_wdata, bi.lsu_wmask} : {1'b0, bi.ifu_addr, 32'h0, 4'h0};
         @(negedge clock);
         total++; if (ctl_a() !== (win ? G_LSU : G_IFU)) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", k, ctl_a(), win ? G_LSU : G_IFU); end
         tick();
         bi.mem_ready = 1;
         @(negedge clock);
         total++; if (ctl_a() !== MREQ) begin bad++; $display("FAIL rr_busy%0d: got %b want %b", k, ctl_a(), MREQ); end
         total++; if (pay_a() !== exp_pay) begin bad++; $display("FAIL rr_payload%0d: got %h want %h", k, pay_a(), exp_pay); end
         tick();
         rd = $urandom;
         bi.mem_ready = 0; bi.mem_rvalid = 1; bi.mem_rdata = rd;
         @(negedge clock);
         total++; if (ctl_a() !== (win ? R_LSU : R_IFU)) begin bad++; $display("FAIL rr_rvalid%0d: got %b want %b", k, ctl_a(), win ? R_LSU : R_IFU); end
         total++; if ((win ? bi.lsu_rdata : bi.ifu_rdata) !== rd) begin bad++; $display("FAIL rr_rdata%0d: got %h want %h", k, win ? bi.lsu_rdata : bi.ifu_rdata, rd); end
         last_lsu_m = win;
         tick();
         bi.mem_rvalid = 0;
         if (k == 2) begin
            bi.ifu_req = 0;
            bi.lsu_req = 0;
         end
      end
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL rr_idle: got %b want %b", ctl_a(), NONE); end
      tick();
   endtask

   task automatic test_store();
      logic [68:0] exp_pay;
      exp_pay = {1'b1, 32'hA0000000, 32'hDEADBEEF, 4'b0011};
      bi.lsu_req = 1; bi.lsu_wen = 1; bi.lsu_addr = 32'hA0000000; bi.lsu_wdata = 32'hDEADBEEF; bi.lsu_wmask = 4'b0011;
      @(negedge clock);
      total++; if (ctl_a() !== G_LSU) begin bad++; $display("FAIL store_gnt: got %b want %b", ctl_a(), G_LSU); end
      tick();
      bi.lsu_req = 0;
      @(negedge clock);
      total++; if (pay_a() !== exp_pay) begin bad++; $display("FAIL store_payload: got %h want %h", pay_a(), exp_pay); end
      tick();
      bi.mem_ready = 1;
      @(negedge clock);
      total++; if (ctl_a() !== MREQ) begin bad++; $display("FAIL store_accept: got %b want %b", ctl_a(), MREQ); end
      tick();
      bi.mem_ready = 0;
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL store_wait: got %b want %b", ctl_a(), NONE); end
      tick();
      bi.mem_rvalid = 1; bi.mem_rdata = $urandom;
      @(negedge clock);
      total++; if (ctl_a() !== R_LSU) begin bad++; $display("FAIL store_ack: got %b want %b", ctl_a(), R_LSU); end
      tick();
      bi.mem_rvalid = 0;
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL store_once: got %b want %b", ctl_a(), NONE); end
      last_lsu_m = 1;
      tick();
   endtask

   task automatic test_stall();
      logic [68:0] exp_pay;
      logic [31:0] rd;
      bi.ifu_req = 1; bi.ifu_addr = $urandom;
      exp_pay = {1'b0, bi.ifu_addr, 32'h0, 4'h0};
      @(negedge clock);
      total++; if (ctl_a() !== G_IFU) begin bad++; $display("FAIL stall_gnt: got %b want %b", ctl_a(), G_IFU); end
      tick();
      // LSU starts waiting while the fetch is stuck
      bi.ifu_req = 0; bi.ifu_addr = $urandom;
      bi.lsu_req = 1; bi.lsu_wen = 0; bi.lsu_addr = $urandom; bi.lsu_wdata = $urandom; bi.lsu_wmask = 4'($urandom);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         total++; if (ctl_a() !== MREQ) begin bad++; $display("FAIL stall_req%0d: got %b want %b", c, ctl_a(), MREQ); end
         total++; if (pay_a() !== exp_pay) begin bad++; $display("FAIL stall_payload%0d: got %h want %h", c, pay_a(), exp_pay); end
         tick();
      end
      bi.mem_ready = 1;
      @(negedge clock);
      total++; if (ctl_a() !== MREQ) begin bad++; $display("FAIL stall_accept: got %b want %b", ctl_a(), MREQ); end
      tick();
      rd = $urandom;
      bi.mem_ready = 0; bi.mem_rvalid = 1; bi.mem_rdata = rd;
      @(negedge clock);
      total++; if (ctl_a() !== R_IFU) begin bad++; $display("FAIL stall_rvalid: got %b want %b", ctl_a(), R_IFU); end
      tick();
      bi.mem_rvalid = 0;
      exp_pay = {1'b0, bi.lsu_addr, bi.lsu_wdata, bi.lsu_wmask};
      @(negedge clock);
      total++; if (ctl_a() !== G_LSU) begin bad++; $display("FAIL stall_held_gnt: got %b want %b", ctl_a(), G_LSU); end
      tick();
      bi.lsu_req = 0; bi.mem_ready = 1;
      @(negedge clock);
      total++; if (pay_a() !== exp_pay) begin bad++; $display("FAIL stall_held_payload: got %h want %h", pay_a(), exp_pay); end
      tick();
      rd = $urandom;
      bi.mem_ready = 0; bi.mem_rvalid = 1; bi.mem_rdata = rd;
      @(negedge clock);
      total++; if (bi.lsu_rdata !== rd || ctl_a() !== R_LSU) begin bad++; $display("FAIL stall_held_rsp: got %b/%h want %b/%h", ctl_a(), bi.lsu_rdata, R_LSU, rd); end
      last_lsu_m = 1;
      tick();
      bi.mem_rvalid = 0;
   endtask

   task automatic test_back_to_back_random();
      bit          want_ifu, want_lsu, win;
      int          rdy_dly, rv_dly;
      logic [31:0] rd;
      logic [68:0] exp_pay;
      logic [6:0]  exp_gnt;
      for (int n = 0; n < 40; n++) begin
         want_ifu = 1'($urandom);
         want_lsu = 1'($urandom);
         if (!want_ifu && !want_lsu) want_ifu = 1;
         win = want_lsu && (!want_ifu || !last_lsu_m);
         bi.ifu_req = want_ifu; bi.ifu_addr = $urandom;
         bi.lsu_req = want_lsu; bi.lsu_wen = 1'($urandom); bi.lsu_addr = $urandom;
         bi.lsu_wdata = $urandom; bi.lsu_wmask = 4'($urandom);
         exp_pay = win ? {bi.lsu_wen, bi.lsu_addr, bi.lsu_wdata, bi.lsu_wmask} : {1'b0, bi.ifu_addr, 32'h0, 4'h0};
         exp_gnt = win ? G_LSU : G_IFU;
         rdy_dly = $urandom_range(0, 3);
         rv_dly  = $urandom_range(0, 3);
         @(negedge clock);
         total++; if (ctl_a() !== exp_gnt) begin bad++; $display("FAIL rnd_gnt%0d: got %b want %b", n, ctl_a(), exp_gnt); end
         tick();
         // stray responses during REQ must be ignored
         for (int d = 0; d < rdy_dly; d++) begin
            bi.mem_ready = 0; bi.mem_rvalid = 1'($urandom); bi.mem_rdata = $urandom;
            @(negedge clock);
            total++; if (ctl_a() !== MREQ || pay_a() !== exp_pay) begin bad++; $display("FAIL rnd_stall%0d: got %b/%h want %b/%h", n, ctl_a(), pay_a(), MREQ, exp_pay); end
            tick();
         end
         bi.mem_ready = 1; bi.mem_rvalid = 1'($urandom);
         @(negedge clock);
         total++; if (ctl_a() !== MREQ || pay_a() !== exp_pay) begin bad++; $display("FAIL rnd_accept%0d: got %b/%h want %b/%h", n, ctl_a(), pay_a(), MREQ, exp_pay); end
         tick();
         bi.mem_ready = 0;
         for (int d = 0; d < rv_dly; d++) begin
            bi.mem_rvalid = 0;
            @(negedge clock);
            total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL rnd_wait%0d: got %b want %b", n, ctl_a(), NONE); end
            tick();
         end
         rd = $urandom;
         bi.mem_rvalid = 1; bi.mem_rdata = rd;
         @(negedge clock);
         total++; if (ctl_a() !== (win ? R_LSU : R_IFU)) begin bad++; $display("FAIL rnd_rvalid%0d: got %b want %b", n, ctl_a(), win ? R_LSU : R_IFU); end
         total++; if ((win ? bi.lsu_rdata : bi.ifu_rdata) !== rd) begin bad++; $display("FAIL rnd_rdata%0d: got %h want %h", n, win ? bi.lsu_rdata : bi.ifu_rdata, rd); end
         last_lsu_m = win;
         tick();
         bi.mem_rvalid = 0; bi.ifu_req = 0; bi.lsu_req = 0;
         if ($urandom_range(0, 3) == 0) begin
            bi.mem_rvalid = 1;
            @(negedge clock);
            total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL rnd_idle_noise%0d: got %b want %b", n, ctl_a(), NONE); end
            tick();
            bi.mem_rvalid = 0;
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd;
      // fetch never accepted: terminates in REQ
      bt.ifu_req = 1; bt.ifu_addr = $urandom; bt.mem_rdata = $urandom | 32'h1;
      @(negedge clock);
      total++; if (ctl_t() !== G_IFU) begin bad++; $display("FAIL tmo_gnt: got %b want %b", ctl_t(), G_IFU); end
      tick();
      bt.ifu_req = 0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         total++; if (ctl_t() !== MREQ) begin bad++; $display("FAIL tmo_req_cycle%0d: got %b want %b", c, ctl_t(), MREQ); end
         tick();
      end
      @(negedge clock);
      total++; if (ctl_t() !== (MREQ | R_IFU | E_IFU)) begin bad++; $display("FAIL tmo_req_fire: got %b want %b", ctl_t(), MREQ | R_IFU | E_IFU); end
      total++; if (bt.ifu_rdata !== 32'h0) begin bad++; $display("FAIL tmo_req_rdata: got %h want 0", bt.ifu_rdata); end
      tick();
      @(negedge clock);
      total++; if (ctl_t() !== NONE) begin bad++; $display("FAIL tmo_req_idle: got %b want %b", ctl_t(), NONE); end
      tick();
      // load accepted but never answered: terminates in WAIT
      bt.lsu_req = 1; bt.lsu_addr = $urandom;
      @(negedge clock);
      total++; if (ctl_t() !== G_LSU) begin bad++; $display("FAIL tmo_wait_gnt: got %b want %b", ctl_t(), G_LSU); end
      tick();
      bt.lsu_req = 0; bt.mem_ready = 1;
      @(negedge clock);
      total++; if (ctl_t() !== MREQ) begin bad++; $display("FAIL tmo_wait_accept: got %b want %b", ctl_t(), MREQ); end
      tick();
      bt.mem_ready = 0;
      for (int c = 2; c <= 4; c++) begin
         @(negedge clock);
         total++; if (ctl_t() !== NONE) begin bad++; $display("FAIL tmo_wait_cycle%0d: got %b want %b", c, ctl_t(), NONE); end
         tick();
      end
      @(negedge clock);
      total++; if (ctl_t() !== (R_LSU | E_LSU)) begin bad++; $display("FAIL tmo_wait_fire: got %b want %b", ctl_t(), R_LSU | E_LSU); end
      total++; if (bt.lsu_rdata !== 32'h0) begin bad++; $display("FAIL tmo_wait_rdata: got %h want 0", bt.lsu_rdata); end
      tick();
      bt.mem_rvalid = 1;
      @(negedge clock);
      total++; if (ctl_t() !== NONE) begin bad++; $display("FAIL tmo_late_rsp: got %b want %b", ctl_t(), NONE); end
      tick();
      bt.mem_rvalid = 0;
      // normal fetch afterwards
      bt.ifu_req = 1; bt.ifu_addr = $urandom;
      @(negedge clock);
      total++; if (ctl_t() !== G_IFU) begin bad++; $display("FAIL tmo_after_gnt: got %b want %b", ctl_t(), G_IFU); end
      tick();
      bt.ifu_req = 0; bt.mem_ready = 1;
      tick();
      rd = $urandom;
      bt.mem_ready = 0; bt.mem_rvalid = 1; bt.mem_rdata = rd;
      @(negedge clock);
      total++; if (ctl_t() !== R_IFU || bt.ifu_rdata !== rd) begin bad++; $display("FAIL tmo_after_rsp: got %b/%h want %b/%h", ctl_t(), bt.ifu_rdata, R_IFU, rd); end
      tick();
      bt.mem_rvalid = 0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      bi.ifu_req = 1; bi.ifu_addr = $urandom;
      @(negedge clock);
      total++; if (ctl_a() !== G_IFU) begin bad++; $display("FAIL rmid_gnt: got %b want %b", ctl_a(), G_IFU); end
      tick();
      bi.ifu_req = 0; bi.mem_ready = 1;
      tick();
      bi.mem_ready = 0;
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL rmid_wait: got %b want %b", ctl_a(), NONE); end
      tick();
      reset = 1; bi.mem_rvalid = 1; bi.mem_rdata = $urandom; bi.lsu_req = 1;
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL rmid_in_reset: got %b want %b", ctl_a(), NONE); end
      total++; if (pay_a() !== 69'h0) begin bad++; $display("FAIL rmid_payload: got %h want 0", pay_a()); end
      tick();
      reset = 0; bi.lsu_req = 0;
      last_lsu_m = 0;
      @(negedge clock);
      total++; if (ctl_a() !== NONE) begin bad++; $display("FAIL rmid_late_rsp: got %b want %b", ctl_a(), NONE); end
      tick();
      // tie right after reset goes to the LSU
      bi.mem_rvalid = 0;
      bi.ifu_req = 1; bi.ifu_addr = $urandom;
      bi.lsu_req = 1; bi.lsu_wen = 0; bi.lsu_addr = $urandom;
      @(negedge clock);
      total++; if (ctl_a() !== G_LSU) begin bad++; $display("FAIL rmid_next_gnt: got %b want %b", ctl_a(), G_LSU); end
      tick();
      bi.ifu_req = 0; bi.lsu_req = 0; bi.mem_ready = 1;
      tick();
      rd = $urandom;
      bi.mem_ready = 0; bi.mem_rvalid = 1; bi.mem_rdata = rd;
      @(negedge clock);
      total++; if (ctl_a() !== R_LSU || bi.lsu_rdata !== rd) begin bad++; $display("FAIL rmid_next_rsp: got %b/%h want %b/%h", ctl_a(), bi.lsu_rdata, R_LSU, rd); end
      last_lsu_m = 1;
      tick();
      bi.mem_rvalid = 0;
   endtask

   initial begin
      reset = 1;
      last_lsu_m = 0;
      clear_inputs();
      test_reset();
      test_basic_fetch();
      test_arbitration();
      test_store();
      test_stall();
      test_back_to_back_random();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
